uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DEFAULT_DIV, 106, reset value of the bit-period divider in clk cycles (106 cycles per bit at the SoC clock).
REQ-002 Parameter LOCK_TIMEOUT, 4096, number of IDLE cycles with the lock owner not valid after which the lock is dropped.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 resetn  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 cfg_div_we  input  1  divider write strobe.
REQ-006 cfg_div_di  input  16  divider write data.
REQ-007 cfg_div_do  output  16  current divider value.
REQ-008 req0_valid / req1_valid  input  1 each  requester has a byte.
REQ-009 req0_data / req1_data  input  8 each  byte to send.
REQ-010 req0_last / req1_last  input  1 each  byte ends the requester's packet.
REQ-011 req0_ready / req1_ready  output  1 each  byte is accepted this cycle when valid and ready are both high.
REQ-012 ser_tx  output  1  8N1 serial line, idle high.
REQ-013 busy  output  1  frame in progress (state not IDLE).
REQ-014 grant_id  output  1  requester owning the current or last frame.
REQ-015 lock_active  output  1  packet lock held.

Function
REQ-016 FSM states: IDLE, START, DATA, STOP; transitions IDLE->START on accept, START->DATA, DATA->STOP after bit 7, STOP->IDLE, each after div cycles.
REQ-017 Divider: a write stores max(cfg_div_di, 2); the value is latched into the frame divider at byte acceptance; a write mid-frame affects only later frames.
REQ-018 Frame: start bit 0, data bits LSB first, stop bit 1, each exactly div cycles; total 10*div cycles.
REQ-019 ser_tx goes low on the cycle after the accept cycle; busy rises on that same cycle.
REQ-020 Readys: in IDLE at most one ready is high, the one for the arbitrated requester; outside IDLE both readys are 0.
REQ-021 Readys are combinational from state, pointer, lock and valids; when neither requester is eligible and valid, both are 0.
REQ-022 Arbitration with no lock: round-robin; if both are valid, grant the requester not served last; if only one is valid, grant it.
REQ-023 Lock set: accepting a byte with last=0 sets the lock to that requester.
REQ-024 While locked: only the owner is eligible; the other requester waits even if the owner is not valid.
REQ-025 Lock release: accepting a byte with last=1 releases the lock, and the pointer advances past the owner.
REQ-026 Lock timeout: an IDLE-cycle counter counts while locked and the owner is not valid; it clears on any owner accept.
REQ-027 On reaching LOCK_TIMEOUT the lock clears on the next cycle and normal round-robin resumes.
REQ-028 An accepted byte is always transmitted completely; input changes during the frame have no effect.
REQ-029 The next accept is possible on the first IDLE cycle after STOP, so back-to-back frames run with 1 idle-high cycle between them.

Reset
REQ-030 On resetn=0 at posedge clk: state IDLE, ser_tx=1, busy=0, readys=0 in that cycle, grant_id=0, lock_active=0, timeout counter=0, divider=DEFAULT_DIV.
REQ-031 On reset the round-robin pointer is set so that requester 0 wins the first tie.
REQ-032 Reset mid-frame aborts the frame: ser_tx is 1 from the next cycle and the byte is dropped.

Verification
REQ-033 div=106, req0 sends 0x41 last=1 -> ser_tx low cycles 1-106 after accept, then bits 1,0,0,0,0,0,1,0, stop high; busy is high for 1060 cycles; a UART monitor sampling mid-bit (53 cycles) decodes 'A'.
REQ-034 Both valid after reset with 0x11 and 0x22, last=1 -> 0x11 is sent first, then 0x22; grant_id goes 0 then 1; a second tie goes to 0.
REQ-035 req0 sends 0x01,0x02,0x03 (last on 0x03) while req1 holds 0x55 valid -> all three req0 bytes precede 0x55; lock_active falls when 0x03 is accepted.
REQ-036 Lock timeout (LOCK_TIMEOUT=16): req0 sends 0x01 last=0 then drops valid, req1 is valid -> req1_ready rises on IDLE cycle 17 after the frame ends.
REQ-037 Divider write 1 -> cfg_div_do=2 and the frame is 20 cycles; a write of 50 mid-frame leaves the current frame at its old timing, and the next frame is 500 cycles.
REQ-038 resetn low at data bit 3 -> ser_tx=1 on the next cycle, busy=0, and the divider returns to 106.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake bundle between the two requesters and the UART transmit arbiter.
// Requesters drive valid/data/last; the arbiter answers with one ready per requester.
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;

    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester 8N1 UART transmitter with round-robin arbitration, packet lock
// (held until a byte with last=1) and an idle timeout that breaks a stalled lock.
module uart_tx_arbiter #(
    parameter int unsigned DEFAULT_DIV  = 106,
    parameter int unsigned LOCK_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cfg_div_we,
    input  logic [15:0]      cfg_div_di,
    output logic [15:0]      cfg_div_do,
    uart_tx_arbiter_if.slave req,
    output logic             ser_tx,
    output logic             busy,
    output logic             grant_id,
    output logic             lock_active
);
    localparam int unsigned     TO_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [15:0]     DIV_RST = 16'(DEFAULT_DIV);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [15:0]     div_q, div_d, fdiv_q, fdiv_d, cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            grant_q, grant_d, rr_q, rr_d;
    logic            lock_q, lock_d, owner_q, owner_d;
    logic [TO_W-1:0] to_q, to_d;

    logic       elig0, elig1, sel1, rdy0, rdy1, accept, acc_last, owner_valid, bit_end;
    logic [7:0] acc_data;

    // rr_q holds the requester served last; a tie goes to the other one.
    always_comb begin
        elig0       = req.req0_valid && (!lock_q || !owner_q);
        elig1       = req.req1_valid && (!lock_q || owner_q);
        sel1        = (elig0 && elig1) ? !rr_q : elig1;
        rdy0        = resetn && (state_q == IDLE) && elig0 && !sel1;
        rdy1        = resetn && (state_q == IDLE) && elig1 && sel1;
        accept      = rdy0 || rdy1;
        acc_data    = sel1 ? req.req1_data : req.req0_data;
        acc_last    = sel1 ? req.req1_last : req.req0_last;
        owner_valid = owner_q ? req.req1_valid : req.req0_valid;
        bit_end     = (cnt_q == fdiv_q - 16'd1);
    end

    assign req.req0_ready = rdy0;
    assign req.req1_ready = rdy1;
    assign cfg_div_do     = div_q;
    assign busy           = (state_q != IDLE);
    assign grant_id       = grant_q;
    assign lock_active    = lock_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        fdiv_d  = fdiv_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        lock_d  = lock_q;
        owner_d = owner_q;
        to_d    = to_q;
        ser_tx  = 1'b1;

        if (cfg_div_we)
            div_d = (cfg_div_di < 16'd2) ? 16'd2 : cfg_div_di;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    fdiv_d  = div_q;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sh_d    = acc_data;
                    grant_d = sel1;
                    rr_d    = sel1;
                    lock_d  = !acc_last;
                    owner_d = sel1;
                    to_d    = '0;
                end else if (lock_q && !owner_valid) begin
                    // Stalled owner: drop the lock once the idle budget is spent.
                    if (to_q == TO_LAST) begin
                        lock_d = 1'b0;
                        to_d   = '0;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
            end
            START: begin
                ser_tx = 1'b0;
                cnt_d  = bit_end ? 16'd0 : cnt_q + 16'd1;
                if (bit_end)
                    state_d = DATA;
            end
            DATA: begin
                ser_tx = sh_q[0];
                cnt_d  = bit_end ? 16'd0 : cnt_q + 16'd1;
                if (bit_end) begin
                    sh_d  = {1'b0, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
                if (bit_end)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            div_q   <= DIV_RST;
            fdiv_q  <= DIV_RST;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            grant_q <= 1'b0;
            rr_q    <= 1'b1;
            lock_q  <= 1'b0;
            owner_q <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            fdiv_q  <= fdiv_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
            to_q    <= to_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus queues the expected serial bytes, an independent UART
// monitor decodes ser_tx mid-bit and checks byte, grant_id and busy length.
module tb_uart_tx_arbiter;
    localparam int DDIV = 106;
    localparam int LTO  = 16;

    typedef struct packed {logic last; logic [7:0] data;} item_t;
    typedef struct packed {logic [7:0] data; logic id; logic [15:0] div;} exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_div_we = 1'b0;
    logic [15:0] cfg_div_di = '0;
    logic [15:0] cfg_div_do;
    logic        ser_tx, busy, grant_id, lock_active;

    uart_tx_arbiter_if rq();

    uart_tx_arbiter #(.DEFAULT_DIV(DDIV), .LOCK_TIMEOUT(LTO)) dut (
        .clk(clk), .resetn(resetn), .cfg_div_we(cfg_div_we), .cfg_div_di(cfg_div_di),
        .cfg_div_do(cfg_div_do), .req(rq), .ser_tx(ser_tx), .busy(busy),
        .grant_id(grant_id), .lock_active(lock_active)
    );

    always #5 clk = ~clk;

    item_t drv0[$], drv1[$];
    exp_t  sb[$];
    int    blen_exp[$];
    int    n_tests = 0, n_fail = 0;
    bit    mon_en = 1'b1, mon_busy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic id, input int dv);
        exp_t e;
        e.data = d; e.id = id; e.div = 16'(dv);
        return e;
    endfunction

    function automatic item_t it(input logic [7:0] d, input logic l);
        item_t i;
        i.data = d; i.last = l;
        return i;
    endfunction

    // Requester drivers: present queue head, pop after an observed handshake.
    initial begin : drv0_p
        logic hs;
        rq.req0_valid = 1'b0; rq.req0_data = '0; rq.req0_last = 1'b0;
        forever begin
            @(negedge clk); hs = rq.req0_valid && rq.req0_ready;
            @(posedge clk); #1;
            if (hs && drv0.size() > 0) void'(drv0.pop_front());
            if (drv0.size() > 0) begin
                rq.req0_valid = 1'b1; rq.req0_data = drv0[0].data; rq.req0_last = drv0[0].last;
            end else rq.req0_valid = 1'b0;
        end
    end

    initial begin : drv1_p
        logic hs;
        rq.req1_valid = 1'b0; rq.req1_data = '0; rq.req1_last = 1'b0;
        forever begin
            @(negedge clk); hs = rq.req1_valid && rq.req1_ready;
            @(posedge clk); #1;
            if (hs && drv1.size() > 0) void'(drv1.pop_front());
            if (drv1.size() > 0) begin
                rq.req1_valid = 1'b1; rq.req1_data = drv1[0].data; rq.req1_last = drv1[0].last;
            end else rq.req1_valid = 1'b0;
        end
    end

    // Busy run-length checker against the length the monitor expects.
    initial begin : blen_p
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            if (!resetn) c = 0;
            else if (busy) c++;
            else if (c > 0) begin
                if (mon_en) begin
                    if (blen_exp.size() == 0) fail("busy_len_unexpected");
                    else chk("busy_len", c, blen_exp.pop_front());
                end
                c = 0;
            end
        end
    end

    // UART monitor: first low cycle is start-bit cycle 1; sample each bit mid-period.
    initial begin : mon_p
        exp_t       e;
        logic [9:0] bits;
        int         cur, tgt;
        forever begin
            @(negedge clk);
            if (mon_en && resetn && ser_tx === 1'b0) begin
                mon_busy = 1'b1;
                if (sb.size() == 0) begin
                    fail("unexpected_frame");
                    e = mk(8'h00, 1'b0, int'(cfg_div_do));
                end else e = sb.pop_front();
                chk("grant_id", grant_id, e.id);
                blen_exp.push_back(10 * int'(e.div));
                cur = 1;
                for (int k = 0; k < 10; k++) begin
                    tgt = k * int'(e.div) + int'(e.div) / 2 + 1;
                    repeat (tgt - cur) @(negedge clk);
                    cur = tgt;
                    bits[k] = ser_tx;
                end
                chk("start_bit", bits[0], 1'b0);
                chk("frame_byte", bits[8:1], e.data);
                chk("stop_bit", bits[9], 1'b1);
                mon_busy = 1'b0;
            end
        end
    end

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || drv0.size() != 0 || drv1.size() != 0 || busy || mon_busy)
               && n < budget) begin
            @(negedge clk); n++;
        end
        if (n >= budget) fail("drain");
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_hs(input bit which, input int bound);
        int n;
        n = 0;
        while (!(which ? (rq.req1_valid && rq.req1_ready) : (rq.req0_valid && rq.req0_ready))
               && n < bound) begin
            @(negedge clk); n++;
        end
        if (n >= bound) fail("handshake");
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        drv0.delete(); drv1.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wr_div(input logic [15:0] v);
        @(negedge clk);
        cfg_div_we = 1'b1; cfg_div_di = v;
        @(negedge clk);
        cfg_div_we = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int c, k, d, np, ln, pk0, pk1, i0, i1;
        bit s, last_s;
        logic [7:0] f0[$], f1[$];
        int l0[$], l1[$];

        // Reset state: readys stay low even with both requesters valid.
        drv0.push_back(it(8'h99, 1'b1)); drv1.push_back(it(8'h66, 1'b1));
        repeat (3) @(negedge clk);
        chk("rst_ready0", rq.req0_ready, 1'b0);
        chk("rst_ready1", rq.req1_ready, 1'b0);
        chk("rst_ser_tx", ser_tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant_id, 1'b0);
        chk("rst_lock", lock_active, 1'b0);
        chk("rst_div", cfg_div_do, 16'd106);
        drv0.delete(); drv1.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // 'A' at default divider; start bit exactly 106 cycles.
        sb.push_back(mk(8'h41, 1'b0, DDIV));
        drv0.push_back(it(8'h41, 1'b1));
        wait_hs(1'b0, 50);
        chk("accept_cycle_ser_tx", ser_tx, 1'b1);
        chk("accept_cycle_busy", busy, 1'b0);
        @(negedge clk);
        chk("after_accept_ser_tx", ser_tx, 1'b0);
        chk("after_accept_busy", busy, 1'b1);
        c = 0;
        while (ser_tx === 1'b0 && c < 1000) begin c++; @(negedge clk); end
        chk("start_low_len", c, 106);
        wait_done(3000);

        // Tie after reset goes to 0, then 1; the next tie goes to 0 again.
        do_reset(); wr_div(16'd8);
        sb.push_back(mk(8'h11, 1'b0, 8)); sb.push_back(mk(8'h22, 1'b1, 8));
        drv0.push_back(it(8'h11, 1'b1)); drv1.push_back(it(8'h22, 1'b1));
        wait_done(1000);
        sb.push_back(mk(8'h33, 1'b0, 8)); sb.push_back(mk(8'h44, 1'b1, 8));
        drv0.push_back(it(8'h33, 1'b1)); drv1.push_back(it(8'h44, 1'b1));
        wait_done(1000);

        // Locked packet from req0 completes before req1's byte.
        do_reset(); wr_div(16'd8);
        sb.push_back(mk(8'h01, 1'b0, 8)); sb.push_back(mk(8'h02, 1'b0, 8));
        sb.push_back(mk(8'h03, 1'b0, 8)); sb.push_back(mk(8'h55, 1'b1, 8));
        drv0.push_back(it(8'h01, 1'b0)); drv0.push_back(it(8'h02, 1'b0));
        drv0.push_back(it(8'h03, 1'b1)); drv1.push_back(it(8'h55, 1'b1));
        c = 0;
        while (!(rq.req0_valid && rq.req0_ready && rq.req0_data == 8'h03) && c < 2000) begin
            @(negedge clk); c++;
        end
        if (c >= 2000) fail("lock_last_accept");
        chk("lock_before_release", lock_active, 1'b1);
        @(negedge clk);
        chk("lock_after_release", lock_active, 1'b0);
        wait_done(2000);

        // Lock timeout: req1 gets ready on idle cycle LTO+1.
        do_reset(); wr_div(16'd8);
        sb.push_back(mk(8'h01, 1'b0, 8)); sb.push_back(mk(8'h77, 1'b1, 8));
        drv0.push_back(it(8'h01, 1'b0)); drv1.push_back(it(8'h77, 1'b1));
        c = 0;
        while (!busy && c < 100) begin @(negedge clk); c++; end
        while (busy && c < 400) begin @(negedge clk); c++; end
        if (c >= 400) fail("timeout_frame");
        chk("timeout_lock_held", lock_active, 1'b1);
        k = 1;
        while (!rq.req1_ready && k < 100) begin @(negedge clk); k++; end
        chk("timeout_ready_cycle", k, LTO + 1);
        wait_done(1000);

        // Divider clamp and mid-frame write.
        do_reset(); wr_div(16'd1);
        chk("div_clamp", cfg_div_do, 16'd2);
        sb.push_back(mk(8'hC3, 1'b0, 2)); sb.push_back(mk(8'h3C, 1'b0, 50));
        drv0.push_back(it(8'hC3, 1'b1)); drv0.push_back(it(8'h3C, 1'b1));
        wait_hs(1'b0, 50);
        repeat (5) @(negedge clk);
        wr_div(16'd50);
        chk("div_write50", cfg_div_do, 16'd50);
        wait_done(3000);

        // Reset during data bit 3 aborts the frame and restores the divider.
        do_reset(); wr_div(16'd20);
        mon_en = 1'b0;
        drv0.push_back(it(8'hA5, 1'b1));
        wait_hs(1'b0, 50);
        repeat (4 * 20 + 10) @(negedge clk);
        chk("abort_busy_before", busy, 1'b1);
        chk("abort_bit3", ser_tx, 1'b0);
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_ser_tx", ser_tx, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_div", cfg_div_do, 16'd106);
        resetn = 1'b1;
        c = 0;
        repeat (40) begin @(negedge clk); if (ser_tx !== 1'b1 || busy) c++; end
        chk("abort_line_idle", c, 0);
        mon_en = 1'b1;

        // Random packets from both sides; model: whole packets, alternating on contention.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            d = $urandom_range(2, 5);
            wr_div(16'(d));
            f0.delete(); f1.delete(); l0.delete(); l1.delete();
            np = $urandom_range(2, 4);
            for (int p = 0; p < np; p++) begin
                ln = $urandom_range(1, 3); l0.push_back(ln);
                for (int j = 0; j < ln; j++) begin
                    f0.push_back(8'($urandom));
                    drv0.push_back(it(f0[f0.size()-1], j == ln - 1));
                end
            end
            np = $urandom_range(2, 4);
            for (int p = 0; p < np; p++) begin
                ln = $urandom_range(1, 3); l1.push_back(ln);
                for (int j = 0; j < ln; j++) begin
                    f1.push_back(8'($urandom));
                    drv1.push_back(it(f1[f1.size()-1], j == ln - 1));
                end
            end
            last_s = 1'b1; pk0 = 0; pk1 = 0; i0 = 0; i1 = 0;
            while (pk0 < l0.size() || pk1 < l1.size()) begin
                if (pk0 < l0.size() && pk1 < l1.size()) s = !last_s;
                else s = (pk0 < l0.size()) ? 1'b0 : 1'b1;
                if (!s) begin
                    for (int j = 0; j < l0[pk0]; j++) begin sb.push_back(mk(f0[i0], 1'b0, d)); i0++; end
                    pk0++;
                end else begin
                    for (int j = 0; j < l1[pk1]; j++) begin sb.push_back(mk(f1[i1], 1'b1, d)); i1++; end
                    pk1++;
                end
                last_s = s;
            end
            wait_done(20000);
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
